// File: rtl/alu_result_skid_if.sv
// alu_result_skid_if
//   Handshake bundle between the DPA2 adder/ALU, the result skid stage and
//   the writeback consumer.
//   Upstream side : in_valid/in_ready plus the adder result
//                   (in_sum, in_cout, in_neg, in_ovf, in_zero, in_aluop).
//   Downstream side: out_valid/out_ready plus the registered result
//                    (out_sum, out_flags={cout,neg,ovf,zero}, out_aluop).
//   slave  : view taken by the skid stage.
//   master : view taken by whoever drives the adder side and consumes results.
interface alu_result_skid_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_sum;
  logic         in_cout;
  logic         in_neg;
  logic         in_ovf;
  logic         in_zero;
  logic [4:0]   in_aluop;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic [3:0]   out_flags;
  logic [4:0]   out_aluop;

  modport slave (
    input  in_valid, in_sum, in_cout, in_neg, in_ovf, in_zero, in_aluop, out_ready,
    output in_ready, out_valid, out_sum, out_flags, out_aluop
  );

  modport master (
    output in_valid, in_sum, in_cout, in_neg, in_ovf, in_zero, in_aluop, out_ready,
    input  in_ready, out_valid, out_sum, out_flags, out_aluop
  );
endinterface

// File: rtl/alu_result_skid.sv
// alu_result_skid
//   Registered output stage behind the combinational DPA2 adder/ALU.
//   A 2-entry skid buffer (main + skid) gives upstream a registered ready and
//   never drops a result under downstream back-pressure. Order is FIFO.
//   Also tracks a sticky overflow bit, a saturating retired-op counter and a
//   zero-flag consistency pulse.
// Ports
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   bus         : alu_result_skid_if.slave (adder result in, registered result out)
//   sticky_clr  : synchronous clear of sticky_ovf (a same-cycle set wins)
//   sticky_ovf  : set once any retired beat carried ovf=1
//   op_count    : retired beats, saturating at 2^CW-1
//   zero_err    : one-cycle pulse, accepted beat had in_zero != (in_sum==0)
module alu_result_skid #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_result_skid_if.slave bus,
  input  logic          sticky_clr,
  output logic          sticky_ovf,
  output logic [CW-1:0] op_count,
  output logic          zero_err
);

  // flags packed as {cout,neg,ovf,zero}
  typedef struct packed {
    logic [N-1:0] sum;
    logic [3:0]   flags;
    logic [4:0]   aluop;
  } beat_t;

  beat_t in_beat, main_q, main_d, skid_q, skid_d;
  logic  main_v, main_v_d, skid_v, skid_v_d;
  logic  accept, retire, zero_mismatch;

  assign in_beat = {bus.in_sum, bus.in_cout, bus.in_neg, bus.in_ovf, bus.in_zero, bus.in_aluop};

  // Ready comes straight from the skid-valid flop: no path from out_ready.
  assign bus.in_ready  = !skid_v;
  assign bus.out_valid = main_v;
  assign bus.out_sum   = main_q.sum;
  assign bus.out_flags = main_q.flags;
  assign bus.out_aluop = main_q.aluop;

  assign accept = bus.in_valid & !skid_v;
  assign retire = main_v & bus.out_ready;
  assign zero_mismatch = bus.in_zero != (bus.in_sum == '0);

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v;
    skid_v_d = skid_v;
    if (!main_v) begin
      // skid is always empty when main is empty
      if (accept) begin
        main_d   = in_beat;
        main_v_d = 1'b1;
      end
    end else if (retire) begin
      if (skid_v) begin
        // in_ready is low here, so no accept can collide with the refill
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d = in_beat;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = in_beat;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      main_v <= main_v_d;
      skid_v <= skid_v_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
      op_count   <= '0;
      zero_err   <= 1'b0;
    end else begin
      // set has priority over clear
      if (retire && main_q.flags[1]) sticky_ovf <= 1'b1;
      else if (sticky_clr)           sticky_ovf <= 1'b0;
      if (retire && (op_count != {CW{1'b1}})) op_count <= op_count + CW'(1);
      // flagged only; the beat itself is stored untouched
      zero_err <= accept && zero_mismatch;
    end
  end

endmodule

// File: tb/tb_alu_result_skid.sv
module tb_alu_result_skid;
  localparam int N  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sticky_clr = 1'b0;
  logic          sticky_ovf;
  logic [CW-1:0] op_count;
  logic          zero_err;

  always #5 clk = ~clk;

  alu_result_skid_if #(.N(N)) bus();

  alu_result_skid #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf),
    .op_count(op_count), .zero_err(zero_err)
  );

  typedef struct packed {
    logic [N-1:0] sum;
    logic [3:0]   flags;
    logic [4:0]   aluop;
  } beat_t;

  // model: mq = beats held by the stage, sent_q/obs_q = accepted/retired this test
  beat_t mq[$], sent_q[$], obs_q[$];
  int    errors = 0, checks = 0;
  int    exp_cnt;
  logic  exp_sticky, exp_zerr;

  function automatic beat_t mk(input logic [N-1:0] s, input logic [3:0] f, input logic [4:0] op);
    beat_t b;
    b.sum = s; b.flags = f; b.aluop = op;
    return b;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.sum   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
    b.flags = 4'($urandom_range(0, 15));
    b.aluop = 5'($urandom_range(0, 31));
    return b;
  endfunction

  task automatic drive(input logic v, input beat_t b);
    bus.in_valid = v;
    bus.in_sum   = b.sum;
    {bus.in_cout, bus.in_neg, bus.in_ovf, bus.in_zero} = b.flags;
    bus.in_aluop = b.aluop;
  endtask

  task automatic model_reset();
    mq.delete();
    exp_cnt = 0; exp_sticky = 1'b0; exp_zerr = 1'b0;
  endtask

  // One clock from negedge to negedge; updates the model from the spec rules.
  task automatic step();
    logic  acc, ret, set;
    beat_t o, b, h;
    acc = bus.in_valid && bus.in_ready;
    ret = bus.out_valid && bus.out_ready;
    set = 1'b0;
    b = mk(bus.in_sum, {bus.in_cout, bus.in_neg, bus.in_ovf, bus.in_zero}, bus.in_aluop);
    if (ret) begin
      o = mk(bus.out_sum, bus.out_flags, bus.out_aluop);
      obs_q.push_back(o);
      if (mq.size() > 0) begin
        h = mq.pop_front();
        set = h.flags[1];
      end
      if (exp_cnt < (1 << CW) - 1) exp_cnt++;
    end
    if (set) exp_sticky = 1'b1;
    else if (sticky_clr) exp_sticky = 1'b0;
    exp_zerr = acc && (b.flags[0] != (b.sum == '0));
    if (acc) begin
      mq.push_back(b);
      sent_q.push_back(b);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, '0);
    bus.out_ready = 1'b0;
    sticky_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sent_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, mk(32'h7, 4'b0010, 5'd3)); step();
    drive(1'b1, mk(32'h8, 4'b0000, 5'd4)); step();
    drive(1'b0, '0);
    bus.out_ready = 1'b1; step();
    checks++;
    if (sticky_ovf !== 1'b1) begin errors++; $display("FAIL reset_pre sticky got=%b exp=1", sticky_ovf); end
    // assert reset in the middle of the low phase, away from any edge
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_sum, bus.out_flags, bus.out_aluop} !== '0) begin
      errors++; $display("FAIL reset_out got v=%b sum=%h fl=%h op=%h exp all 0",
                         bus.out_valid, bus.out_sum, bus.out_flags, bus.out_aluop);
    end
    checks++;
    if ({sticky_ovf, op_count, zero_err} !== '0) begin
      errors++; $display("FAIL reset_status got sticky=%b cnt=%0d zerr=%b exp 0", sticky_ovf, op_count, zero_err);
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset(); sent_q.delete(); obs_q.delete();
    step();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release got rdy=%b v=%b exp rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    drive(1'b1, mk(32'h0000_0005, 4'b0000, 5'b00010)); step();
    drive(1'b0, '0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 32'h5 || bus.out_aluop !== 5'b00010 || bus.out_flags !== 4'h0) begin
      errors++; $display("FAIL single_out got v=%b sum=%h op=%b exp v=1 sum=5 op=00010",
                         bus.out_valid, bus.out_sum, bus.out_aluop);
    end
    step();
    checks++;
    if (op_count !== 4'd1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_count got cnt=%0d v=%b exp cnt=1 v=0", op_count, bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    sent_q.delete(); obs_q.delete();
    bus.out_ready = 1'b0;
    drive(1'b1, mk(32'h11, 4'h0, 5'd1)); step();
    drive(1'b1, mk(32'h22, 4'h0, 5'd2)); step();
    drive(1'b0, '0);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", bus.in_ready); end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 32'h11 || bus.out_aluop !== 5'd1) begin
      errors++; $display("FAIL bp_hold got v=%b sum=%h exp v=1 sum=11", bus.out_valid, bus.out_sum);
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 32'h22 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second got v=%b sum=%h rdy=%b exp v=1 sum=22 rdy=1",
                         bus.out_valid, bus.out_sum, bus.in_ready);
    end
    step();
    checks++;
    if (obs_q.size() != 2 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_count got n=%0d v=%b exp n=2 v=0", obs_q.size(), bus.out_valid);
    end else begin
      checks++;
      if (obs_q[0].sum !== 32'h11 || obs_q[1].sum !== 32'h22) begin
        errors++; $display("FAIL bp_order got %h,%h exp 11,22", obs_q[0].sum, obs_q[1].sum);
      end
    end
  endtask

  task automatic test_stream();
    int rdy_low;
    sent_q.delete(); obs_q.delete();
    rdy_low = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.in_ready !== 1'b1) rdy_low++;
      drive(1'b1, rand_beat()); step();
    end
    drive(1'b0, '0);
    step();
    checks++;
    if (rdy_low != 0 || sent_q.size() != 8 || obs_q.size() != 8) begin
      errors++; $display("FAIL stream_rate got rdy_low=%0d sent=%0d out=%0d exp 0,8,8",
                         rdy_low, sent_q.size(), obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < sent_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== sent_q[i]) begin
        errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, obs_q[i], sent_q[i]);
      end
    end
  endtask

  task automatic test_sticky();
    bus.out_ready = 1'b1;
    drive(1'b0, '0);
    sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
    checks++;
    if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL sticky_init got=%b exp=0", sticky_ovf); end
    drive(1'b1, mk(32'h8000_0000, 4'b0110, 5'd6)); step();
    drive(1'b0, '0); step();
    checks++;
    if (sticky_ovf !== 1'b1) begin errors++; $display("FAIL sticky_set got=%b exp=1", sticky_ovf); end
    drive(1'b1, mk(32'h7FFF_FFFF, 4'b0010, 5'd7)); step();
    drive(1'b0, '0);
    sticky_clr = 1'b1; step();
    checks++;
    if (sticky_ovf !== 1'b1) begin errors++; $display("FAIL sticky_setwins got=%b exp=1", sticky_ovf); end
    step(); sticky_clr = 1'b0;
    checks++;
    if (sticky_ovf !== 1'b0) begin errors++; $display("FAIL sticky_clr got=%b exp=0", sticky_ovf); end
  endtask

  task automatic test_zero_sat();
    sent_q.delete(); obs_q.delete();
    bus.out_ready = 1'b1;
    drive(1'b1, mk(32'h0, 4'b0000, 5'd9)); step();
    checks++;
    if (zero_err !== 1'b1) begin errors++; $display("FAIL zero_bad got=%b exp=1", zero_err); end
    drive(1'b1, mk(32'h0, 4'b0001, 5'd9)); step();
    checks++;
    if (zero_err !== 1'b0) begin errors++; $display("FAIL zero_pulse got=%b exp=0", zero_err); end
    drive(1'b1, mk(32'h100, 4'b0001, 5'd9)); step();
    checks++;
    if (zero_err !== 1'b1) begin errors++; $display("FAIL zero_nonzero got=%b exp=1", zero_err); end
    drive(1'b0, '0); step();
    checks++;
    if (zero_err !== 1'b0) begin errors++; $display("FAIL zero_idle got=%b exp=0", zero_err); end
    checks++;
    if (obs_q.size() != 3 || obs_q[0] !== mk(32'h0, 4'b0000, 5'd9) || obs_q[2] !== mk(32'h100, 4'b0001, 5'd9)) begin
      errors++; $display("FAIL zero_passthru got n=%0d exp 3 unmodified beats", obs_q.size());
    end
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin drive(1'b1, rand_beat()); step(); end
    drive(1'b0, '0); step();
    checks++;
    if (op_count !== 4'd15 || obs_q.size() != 17) begin
      errors++; $display("FAIL sat_count got cnt=%0d retired=%0d exp cnt=15 retired=17", op_count, obs_q.size());
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      drive(($urandom_range(0, 9) < 7), rand_beat());
      bus.out_ready = ($urandom_range(0, 9) < 6);
      sticky_clr    = ($urandom_range(0, 9) == 0);
      if (bus.out_valid && mq.size() > 0) begin
        checks++;
        if ({bus.out_sum, bus.out_flags, bus.out_aluop} !== mq[0]) begin
          errors++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c,
                             {bus.out_sum, bus.out_flags, bus.out_aluop}, mq[0]);
        end
      end
      step();
      checks++;
      if (bus.out_valid !== (mq.size() > 0) || bus.in_ready !== (mq.size() < 2) ||
          op_count !== CW'(exp_cnt) || sticky_ovf !== exp_sticky || zero_err !== exp_zerr) begin
        errors++; bad++;
        if (bad < 10)
          $display("FAIL rnd_state c=%0d got v=%b rdy=%b cnt=%0d st=%b ze=%b exp v=%b rdy=%b cnt=%0d st=%b ze=%b",
                   c, bus.out_valid, bus.in_ready, op_count, sticky_ovf, zero_err,
                   mq.size() > 0, mq.size() < 2, exp_cnt, exp_sticky, exp_zerr);
      end
    end
    drive(1'b0, '0);
    sticky_clr = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (obs_q.size() != sent_q.size() || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rnd_drain got out=%0d v=%b exp out=%0d v=0", obs_q.size(), bus.out_valid, sent_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < sent_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== sent_q[i]) begin
        errors++; $display("FAIL rnd_order[%0d] got=%h exp=%h", i, obs_q[i], sent_q[i]);
      end
    end
  endtask

  initial begin
    drive(1'b0, '0);
    bus.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_sticky();
    test_zero_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
